// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 target (CPOL=0, CPHA=0) running entirely in the
// ACLK domain. SCLK, CS_n and MOSI are oversampled through synchronizers and
// their edges are detected in ACLK, so SCLK must be at least 8x slower than ACLK.
//
// Ports
//   ACLK         system clock, all state changes on its rising edge
//   reset        asynchronous, active-high reset
//   SCLK/CS_n/MOSI  SPI inputs from the initiator (asynchronous to ACLK)
//   MISO         serial response data, MSB first, 0 when not selected
//   miso_oe      high while the synchronized select is active
//   tx_data/tx_valid/tx_ready  one-entry response buffer, valid/ready handshake
//   rx_data/rx_valid           last complete frame plus one-cycle update pulse
//   tx_underrun  one-cycle pulse, a frame started with the buffer empty
//   frame_abort  one-cycle pulse, select dropped with a partial frame
module spi_responder #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              ACLK,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BYTE_DONE
    } state_t;

    // Synchronizers plus one extra registered copy for edge detection
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_buf;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_underrun;
    logic              r_frame_abort;

    logic             w_wr;
    logic             w_load;
    logic [CNT_W-1:0] w_cnt_inc;

    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync[0] <= SCLK;
            r_cs_sync[0]   <= CS_n;
            r_mosi_sync[0] <= MOSI;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

    assign w_wr      = tx_valid & ~r_buf_full;
    assign w_cnt_inc = r_bit_cnt + CNT_W'(1);

    // A frame end coincident with select release goes straight to IDLE and
    // does not consume the buffer, so no reload and no underrun there.
    always_comb begin
        w_load = 1'b0;
        if ((r_state == ST_IDLE) && w_cs_fall)
            w_load = 1'b1;
        else if ((r_state == ST_BYTE_DONE) && !w_cs_rise)
            w_load = 1'b1;
    end

    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_abort <= 1'b0;

            // A write in the same cycle as a load hands the load the register's
            // previous contents and keeps the new byte buffered.
            if (w_wr) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            if (w_load) begin
                if (r_buf_full || w_wr) begin
                    r_tx_shift <= r_buf;
                end else begin
                    r_tx_shift    <= '0;
                    r_tx_underrun <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        if ((r_bit_cnt != '0) && (r_bit_cnt < LAST_BIT))
                            r_frame_abort <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
                        r_bit_cnt  <= w_cnt_inc;
                        if (w_cnt_inc == LAST_BIT)
                            r_state <= ST_BYTE_DONE;
                    end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        // The falling edge right after a (re)load would drop
                        // the MSB before it is sampled, hence the count guard.
                        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                    end
                end

                ST_BYTE_DONE: begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_state    <= w_cs_rise ? ST_IDLE : ST_SHIFT;
                end

                default: begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso_oe     = ~w_cs_s;
    assign MISO        = ~w_cs_s & r_tx_shift[DATA_W-1];
    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed scoreboard bench for spi_responder.
// Stimulus pushes expected MISO bits, received frames and pulse events into
// queues; monitors pop and compare when the DUT presents them.
module tb_spi_responder;

    localparam int unsigned DW = 8;

    logic          ACLK = 1'b0;
    logic          reset = 1'b1;
    logic          SCLK = 1'b0;
    logic          CS_n = 1'b1;
    logic          MOSI = 1'b0;
    logic          MISO;
    logic          miso_oe;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_underrun;
    logic          frame_abort;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic          q_miso[$];
    logic [DW-1:0] q_rx[$];
    int unsigned   q_urun[$];
    int unsigned   q_abort[$];
    int unsigned   test_id = 0;

    spi_responder #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .ACLK        (ACLK),
        .reset       (reset),
        .SCLK        (SCLK),
        .CS_n        (CS_n),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (test %0d): got 0x%0h expected 0x%0h", name, test_id, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (test %0d): event seen, none expected", name, test_id);
    endtask

    // MISO monitor: the initiator samples on SCLK rising
    always @(posedge SCLK) begin
        if (q_miso.size() == 0) begin
            unexpected("miso_extra_bit");
        end else begin
            check("miso_bit", 32'(MISO), 32'(q_miso.pop_front()));
            check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
        end
    end

    // Pulse monitor, sampled away from the active edge
    always @(negedge ACLK) begin
        if (!reset) begin
            if (rx_valid === 1'b1) begin
                if (q_rx.size() == 0) unexpected("rx_valid_extra");
                else check("rx_data", 32'(rx_data), 32'(q_rx.pop_front()));
            end
            if (tx_underrun === 1'b1) begin
                if (q_urun.size() == 0) unexpected("tx_underrun_extra");
                else void'(q_urun.pop_front());
            end
            if (frame_abort === 1'b1) begin
                if (q_abort.size() == 0) unexpected("frame_abort_extra");
                else void'(q_abort.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic tx_write(input logic [DW-1:0] d);
        int unsigned n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        if (tx_ready !== 1'b1) unexpected("tx_write_timeout");
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        CS_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(5);
        CS_n = 1'b1;
        tick(8);
    endtask

    // mode 0: plain bit, 1: release CS one cycle after the rise,
    // 2: write wr_d so it lands in the BYTE_DONE cycle
    task automatic spi_bit(input logic b, input logic exp, input int unsigned mode,
                           input logic [DW-1:0] wr_d);
        MOSI = b;
        tick(5);
        q_miso.push_back(exp);
        SCLK = 1'b1;
        if (mode == 1) begin
            tick(1);
            CS_n = 1'b1;
            tick(4);
        end else if (mode == 2) begin
            tick(3);
            tx_data  = wr_d;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            tick(1);
        end else begin
            tick(5);
        end
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [DW-1:0] mosi_b, input logic [DW-1:0] miso_b,
                            input int unsigned last_mode, input logic [DW-1:0] wr_d);
        for (int i = DW - 1; i >= 0; i--)
            spi_bit(mosi_b[i], miso_b[i], (i == 0) ? last_mode : 0, wr_d);
        if (last_mode == 1) tick(10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_MISO"},        32'(MISO),        32'd0);
        check({tag, "_miso_oe"},     32'(miso_oe),     32'd0);
        check({tag, "_tx_ready"},    32'(tx_ready),    32'd1);
        check({tag, "_rx_data"},     32'(rx_data),     32'd0);
        check({tag, "_rx_valid"},    32'(rx_valid),    32'd0);
        check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] abort_mosi;
        logic [DW-1:0] abort_miso;

        tick(3);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        tick(5);
        check_reset_outputs("after_reset");

        // Single byte
        test_id = 1;
        tx_write(8'hA5);
        check("tx_ready_full", 32'(tx_ready), 32'd0);
        cs_low();
        q_rx.push_back(8'h3C);
        q_urun.push_back(test_id);
        spi_byte(8'h3C, 8'hA5, 0, '0);
        cs_high();
        check("miso_oe_deselected", 32'(miso_oe), 32'd0);

        // Two-byte burst, select released in the BYTE_DONE cycle
        test_id = 2;
        tx_write(8'h11);
        cs_low();
        tx_write(8'h22);
        q_rx.push_back(8'hF0);
        spi_byte(8'hF0, 8'h11, 0, '0);
        q_rx.push_back(8'h0F);
        spi_byte(8'h0F, 8'h22, 1, '0);

        // Underrun
        test_id = 3;
        q_urun.push_back(test_id);
        cs_low();
        q_rx.push_back(8'h55);
        spi_byte(8'h55, 8'h00, 1, '0);

        // Abort after 5 bits, then a clean frame
        test_id = 4;
        abort_mosi = 8'hE7;
        abort_miso = 8'h96;
        tx_write(8'h96);
        cs_low();
        for (int i = DW - 1; i >= 3; i--)
            spi_bit(abort_mosi[i], abort_miso[i], 0, '0);
        q_abort.push_back(test_id);
        cs_high();
        check("abort_miso_oe", 32'(miso_oe), 32'd0);
        check("abort_MISO", 32'(MISO), 32'd0);
        tx_write(8'h3C);
        cs_low();
        q_rx.push_back(8'h6B);
        spi_byte(8'h6B, 8'h3C, 1, '0);

        // Reset after bit 3
        test_id = 5;
        q_urun.push_back(test_id);
        cs_low();
        spi_bit(1'b1, 1'b0, 0, '0);
        spi_bit(1'b0, 1'b0, 0, '0);
        spi_bit(1'b1, 1'b0, 0, '0);
        tick(2);
        reset = 1'b1;
        CS_n  = 1'b1;
        MOSI  = 1'b0;
        tick(3);
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        tick(10);
        check_reset_outputs("post_reset_quiet");
        tx_write(8'h42);
        cs_low();
        q_rx.push_back(8'h81);
        spi_byte(8'h81, 8'h42, 1, '0);
        check("rx_data_hold_81", 32'(rx_data), 32'h81);

        // Write coincident with the BYTE_DONE reload
        test_id = 6;
        tx_write(8'h5A);
        cs_low();
        q_rx.push_back(8'h12);
        spi_byte(8'h12, 8'h5A, 2, 8'hC3);
        check("tx_ready_after_coincident_write", 32'(tx_ready), 32'd0);
        q_rx.push_back(8'h34);
        spi_byte(8'h34, 8'h5A, 0, '0);
        q_rx.push_back(8'h56);
        spi_byte(8'h56, 8'hC3, 1, '0);
        check("tx_ready_drained", 32'(tx_ready), 32'd1);

        tick(20);
        check("miso_bits_pending",  32'(q_miso.size()),  32'd0);
        check("rx_frames_pending",  32'(q_rx.size()),    32'd0);
        check("underrun_pending",   32'(q_urun.size()),  32'd0);
        check("abort_pending",      32'(q_abort.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
